// File: rtl/morse_pkg.sv
// Shared types and sizes for the Morse letter sequencer.
// Every file of the block imports this package.
package morse_pkg;

    localparam int unsigned MAX_SYMBOLS = 5;
    localparam int unsigned CODE_W      = MAX_SYMBOLS;
    localparam int unsigned LEN_W       = $clog2(MAX_SYMBOLS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        EMIT      = 2'd2,
        WORD_WAIT = 2'd3
    } state_e;

endpackage : morse_pkg

// File: rtl/morse_gap_timer.sv
// Saturating key-released gap counter. It clears on clr and otherwise counts
// up to max, where it holds until the next clear.
module morse_gap_timer #(
    parameter int unsigned WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != max) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : morse_gap_timer

// File: rtl/morse_letter_sequencer.sv
// Groups dot/dash pulses into letters, presents each letter with a valid/ready
// handshake, and marks word boundaries from the length of key-released gaps.
module morse_letter_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned LETTER_GAP = 3_000_000,
    parameter int unsigned WORD_GAP   = 7_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              b,
    input  logic              dot,
    input  logic              dash,
    input  logic              ready,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic [LEN_W-1:0]  len,
    output logic              overflow,
    output logic              word_space,
    output logic              sym_lost
);

    localparam int unsigned GAP_W = $clog2(WORD_GAP + 1);
    localparam logic [GAP_W-1:0] LETTER_GAP_C = GAP_W'(LETTER_GAP);
    localparam logic [GAP_W-1:0] WORD_GAP_C   = GAP_W'(WORD_GAP);
    localparam logic [LEN_W-1:0] MAX_LEN_C    = LEN_W'(MAX_SYMBOLS);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic              sym_lost_q, sym_lost_d;
    logic              word_space_c;

    logic              sym_ev;
    logic [GAP_W-1:0]  gap_count;

    // Simultaneous dot and dash is a decoder glitch and is not a symbol.
    assign sym_ev = dot ^ dash;

    morse_gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (b | sym_ev),
        .max     (WORD_GAP_C),
        .count   (gap_count)
    );

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        len_d        = len_q;
        overflow_d   = overflow_q;
        valid_d      = valid_q;
        sym_lost_d   = 1'b0;
        word_space_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sym_ev) begin
                    code_d     = {{(CODE_W-1){1'b0}}, dash};
                    len_d      = LEN_W'(1);
                    overflow_d = 1'b0;
                    state_d    = COLLECT;
                end
            end

            COLLECT: begin
                if (sym_ev) begin
                    if (len_q < MAX_LEN_C) begin
                        code_d = {code_q[CODE_W-2:0], dash};
                        len_d  = len_q + LEN_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (gap_count == LETTER_GAP_C) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                end
            end

            EMIT: begin
                // The presented letter is frozen; late symbols are reported, not stored.
                sym_lost_d = sym_ev;
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    state_d = WORD_WAIT;
                end
            end

            WORD_WAIT: begin
                if (sym_ev) begin
                    code_d     = {{(CODE_W-1){1'b0}}, dash};
                    len_d      = LEN_W'(1);
                    overflow_d = 1'b0;
                    state_d    = COLLECT;
                end else if (gap_count == WORD_GAP_C) begin
                    // Decoded from state so a gap that saturated during EMIT
                    // is reported in the very first WORD_WAIT cycle.
                    word_space_c = 1'b1;
                    len_d        = '0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            code_q     <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            sym_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            sym_lost_q <= sym_lost_d;
        end
    end

    assign valid      = valid_q;
    assign code       = code_q;
    assign len        = len_q;
    assign overflow   = overflow_q;
    assign word_space = word_space_c;
    assign sym_lost   = sym_lost_q;

endmodule : morse_letter_sequencer

// File: tb/tb_morse_letter_sequencer.sv
// Directed bench for morse_letter_sequencer with LETTER_GAP=8, WORD_GAP=20.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_morse_letter_sequencer;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       b, dot, dash, ready;
    logic       valid, overflow, word_space, sym_lost;
    logic [4:0] code;
    logic [2:0] len;

    int checks = 0;
    int errors = 0;

    morse_letter_sequencer #(
        .LETTER_GAP (8),
        .WORD_GAP   (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .b          (b),
        .dot        (dot),
        .dash       (dash),
        .ready      (ready),
        .valid      (valid),
        .code       (code),
        .len        (len),
        .overflow   (overflow),
        .word_space (word_space),
        .sym_lost   (sym_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic is_dash);
        dot  = ~is_dash;
        dash = is_dash;
        step();
        dot  = 1'b0;
        dash = 1'b0;
    endtask

    initial begin
        int n_valid, first_valid, ws_count, ws_at, valid_at;

        reset_n = 1'b0;
        b = 1'b0; dot = 1'b0; dash = 1'b0; ready = 1'b0;
        #1;
        check("reset_outputs", {valid, code, len, overflow, word_space, sym_lost}, '0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        step(); step();
        reset_n = 1'b1;
        repeat (3) step();

        // Letter dot-dash-dot with 3-cycle gaps, ready already high.
        ready = 1'b1;
        send(1'b0);
        check("l1_len1", 32'(len), 32'd1);
        check("l1_state_collect", 32'(dut.state_q), 32'(COLLECT));
        repeat (3) step();
        send(1'b1);
        check("l1_code2", 32'(code), 32'b00001);
        check("l1_len2", 32'(len), 32'd2);
        repeat (3) step();
        send(1'b0);
        check("l1_len3", 32'(len), 32'd3);

        n_valid = 0;
        first_valid = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (valid) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = i;
                    check("l1_code", 32'(code), 32'b00010);
                    check("l1_len", 32'(len), 32'd3);
                    check("l1_ovf", 32'(overflow), 32'd0);
                end
            end
        end
        check("l1_valid_cycles", 32'(n_valid), 32'd1);
        check("l1_valid_latency", 32'(first_valid), 32'd9);

        // No key activity after acceptance: word gap completes 10 cycles later.
        ws_count = 0;
        ws_at = -1;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (word_space) begin
                ws_count++;
                if (ws_at < 0) ws_at = j;
            end
        end
        check("ws_pulses", 32'(ws_count), 32'd1);
        check("ws_timing", 32'(ws_at), 32'd8);
        check("ws_len0", 32'(len), 32'd0);
        check("ws_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Overflow letter dash,dash,dot,dot,dash,dot with ready held low.
        ready = 1'b0;
        send(1'b1); step();
        send(1'b1); step();
        send(1'b0); step();
        send(1'b0); step();
        send(1'b1);
        check("ov_code5", {code, len, overflow}, {5'b11001, 3'd5, 1'b0});
        step();
        send(1'b0);
        check("ov_code6", {code, len, overflow}, {5'b11001, 3'd5, 1'b1});

        valid_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (valid) begin
                valid_at = i;
                break;
            end
        end
        check("ov_valid_latency", 32'(valid_at), 32'd9);
        check("ov_presented", {valid, code, len, overflow}, {1'b1, 5'b11001, 3'd5, 1'b1});

        // Stall in EMIT and inject a dot that must be dropped.
        repeat (5) step();
        check("stall_valid", 32'(valid), 32'd1);
        dot = 1'b1;
        step();
        dot = 1'b0;
        check("sym_lost_pulse", 32'(sym_lost), 32'd1);
        check("stall_after_dot", {valid, code, len, overflow}, {1'b1, 5'b11001, 3'd5, 1'b1});
        check("stall_state", 32'(dut.state_q), 32'(EMIT));
        step();
        check("sym_lost_clear", 32'(sym_lost), 32'd0);
        for (int k = 0; k < 23; k++) begin
            step();
            check("stall_hold", {valid, code, len, overflow, sym_lost},
                  {1'b1, 5'b11001, 3'd5, 1'b1, 1'b0});
        end

        // Accept after the gap has saturated: word_space in the first WORD_WAIT cycle.
        ready = 1'b1;
        step();
        check("acc_valid_low", 32'(valid), 32'd0);
        check("acc_state_ww", 32'(dut.state_q), 32'(WORD_WAIT));
        check("acc_word_space", 32'(word_space), 32'd1);
        step();
        check("acc_ws_clear", 32'(word_space), 32'd0);
        check("acc_idle_len", 32'(len), 32'd0);
        check("acc_state_idle", 32'(dut.state_q), 32'(IDLE));

        // dot and dash together are ignored in IDLE.
        dot = 1'b1;
        dash = 1'b1;
        step();
        dot = 1'b0;
        dash = 1'b0;
        check("both_len", 32'(len), 32'd0);
        check("both_state", 32'(dut.state_q), 32'(IDLE));
        check("both_sym_lost", 32'(sym_lost), 32'd0);

        // Reset in the middle of collecting a two-symbol letter.
        send(1'b0);
        step();
        send(1'b1);
        check("rst_pre_len", 32'(len), 32'd2);
        check("rst_pre_state", 32'(dut.state_q), 32'(COLLECT));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_outputs", {valid, code, len, overflow, word_space, sym_lost}, '0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        step(); step();
        reset_n = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid) n_valid++;
        end
        check("rst_no_valid", 32'(n_valid), 32'd0);
        check("rst_len", 32'(len), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish within 50000 time units");
        $fatal(1);
    end

endmodule : tb_morse_letter_sequencer

// File: doc/morse_letter_sequencer.md
MORSE_LETTER_SEQUENCER -- requirements
Module: morse_letter_sequencer

Interface
REQ-001 Parameter LETTER_GAP, 3_000_000, number of consecutive key-released cycles that ends a letter; it SHALL be at least 2.
REQ-002 Parameter WORD_GAP, 7_000_000, number of consecutive key-released cycles that ends a word; it SHALL be greater than LETTER_GAP.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 b  input  1  debounced key level; 1 = pressed.
REQ-006 dot  input  1  one-cycle pulse from the decoder: a dot was keyed.
REQ-007 dash  input  1  one-cycle pulse from the decoder: a dash was keyed.
REQ-008 ready  input  1  consumer accepts the presented letter.
REQ-009 valid  output  1  a letter is presented on code/len/overflow.
REQ-010 code  output  5  symbols, first symbol in the most significant used bit, LSB = last symbol; 1 = dash.
REQ-011 len  output  3  symbol count, 0..5; also the live count while collecting, for display.
REQ-012 overflow  output  1  the current letter received more than 5 symbols.
REQ-013 word_space  output  1  one-cycle pulse when a word gap completes.
REQ-014 sym_lost  output  1  one-cycle pulse when a symbol is dropped while waiting for ready.

Function
REQ-015 A symbol event SHALL be dot XOR dash; dot and dash high in the same cycle SHALL be ignored and SHALL NOT change any state.
REQ-016 The gap counter SHALL:
- clear in any cycle where b=1 or a symbol event occurs;
- otherwise increment, saturating at WORD_GAP;
- be sized $clog2(WORD_GAP+1) bits.
REQ-017 The FSM SHALL have exactly the states IDLE, COLLECT, EMIT and WORD_WAIT.
REQ-018 IDLE on a symbol event SHALL load code={4'b0,dash}, set len=1, clear overflow, and go to COLLECT.
REQ-019 COLLECT on a symbol event with len<5 SHALL set code={code[3:0],dash} and increment len.
REQ-020 COLLECT on a symbol event with len=5 SHALL keep code and len unchanged and set overflow=1.
REQ-021 COLLECT SHALL go to EMIT in the cycle after the gap counter equals LETTER_GAP.
REQ-022 EMIT SHALL drive valid=1, holding code, len and overflow stable until valid&&ready.
REQ-023 EMIT on valid&&ready SHALL go to WORD_WAIT, with valid=0 on the next cycle; this is a single-cycle transfer.
REQ-024 EMIT SHALL NOT change any state on a symbol event; it SHALL pulse sym_lost for one cycle.
REQ-025 The gap counter SHALL keep counting through EMIT.
REQ-026 WORD_WAIT on a symbol event SHALL behave as REQ-018 and go to COLLECT.
REQ-027 WORD_WAIT with gap counter = WORD_GAP SHALL pulse word_space for one cycle, set len=0, and go to IDLE.
REQ-028 If ready arrives after the gap has already saturated, word_space SHALL pulse in the first WORD_WAIT cycle.
REQ-029 valid SHALL be a registered output and SHALL NOT depend combinationally on ready.
REQ-030 Latency:
- symbol event to len update: 1 cycle;
- gap reaching LETTER_GAP to valid=1: 1 cycle.

Reset
REQ-031 When reset_n=0, the block SHALL immediately set:
- state to IDLE;
- code=0, len=0, overflow=0, valid=0, word_space=0, sym_lost=0;
- gap counter to 0.
REQ-032 Reset mid-operation SHALL discard the partial or presented letter, with no valid on release.

Structure
REQ-033 Package morse_pkg SHALL hold the FSM state enum, MAX_SYMBOLS=5, and the code/len widths.
REQ-034 The gap counter SHALL be the sub-module morse_gap_timer, with inputs clr and max and output count.
REQ-035 The FSM and symbol register SHALL reside in morse_letter_sequencer.

Verification (LETTER_GAP=8, WORD_GAP=20)
REQ-036 The bench SHALL cover dot, dash, dot with gaps of 3 cycles, then idle with ready=1 -> valid=1 for exactly 1 cycle with code=00010, len=3, overflow=0.
REQ-037 The bench SHALL cover the sequence dash, dash, dot, dot, dash, dot -> code=11001, len=5, overflow=1.
REQ-038 The bench SHALL cover ready=0 held for 30 cycles with a dot injected during EMIT -> code/len stable, one sym_lost pulse, and acceptance on ready=1.
REQ-039 The bench SHALL cover the case of no key activity after acceptance -> one word_space pulse at gap=20, then state IDLE with len=0.
REQ-040 The bench SHALL cover reset_n=0 asserted mid-COLLECT at len=2 -> all outputs 0 immediately, and no valid after release.
REQ-041 The bench SHALL cover dot=dash=1 for one cycle in IDLE -> len stays 0 and state stays IDLE.
